// File: rtl/sdram_ext_arbiter.sv
// Purpose: two-master arbiter sharing the SDRAM controller Ext command port.
// Latency: ExtReq one edge after the Req-sampling edge; Mx_Ready one edge after ExtReady is seen low again.
// Backpressure: whole transactions are serialised; the other master's Req is held off until IDLE.
//
// Ports:
//   PixelClk2, RESETn              clock, asynchronous active-low reset
//   M0_* / M1_*                    master command ports (Addr, DataWrite, DataMask, OP, Req)
//                                  and completion (Ready, DataRead), 4-phase handshake
//   Ext*                           registered command to / response from the SDRAM controller
//   Grant                          one-hot owner of the current transaction, 00 in IDLE
//   Timeout                        sticky flag: ISSUE lasted TIMEOUT cycles without ExtReady
module sdram_ext_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 4096
) (
  input  logic        PixelClk2,
  input  logic        RESETn,
  input  logic [23:0] M0_Addr,
  input  logic [15:0] M0_DataWrite,
  input  logic [1:0]  M0_DataMask,
  input  logic        M0_OP,
  input  logic        M0_Req,
  output logic        M0_Ready,
  output logic [15:0] M0_DataRead,
  input  logic [23:0] M1_Addr,
  input  logic [15:0] M1_DataWrite,
  input  logic [1:0]  M1_DataMask,
  input  logic        M1_OP,
  input  logic        M1_Req,
  output logic        M1_Ready,
  output logic [15:0] M1_DataRead,
  output logic [23:0] ExtAddr,
  output logic [15:0] ExtDataWrite,
  output logic [1:0]  ExtDataMask,
  output logic        ExtOP,
  output logic        ExtReq,
  input  logic        ExtReady,
  input  logic [15:0] ExtDataRead,
  output logic [1:0]  Grant,
  output logic        Timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state;
  state_t      state_next;
  logic        last_grant;   // 0 = M0, 1 = M1
  logic [15:0] wd_cnt;

  logic        grant_en;
  logic        grant_sel;    // master chosen this cycle: 0 = M0, 1 = M1
  logic        capture_en;
  logic        ready_set;
  logic        ready_clr;
  logic        owner_req;

  // Grant[1] doubles as the owner index for the whole transaction.
  assign owner_req = Grant[1] ? M1_Req : M0_Req;

  always_ff @(posedge PixelClk2 or negedge RESETn) begin
    if (!RESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    grant_sel  = 1'b0;
    capture_en = 1'b0;
    ready_set  = 1'b0;
    ready_clr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (M0_Req && M1_Req) begin
          grant_en  = 1'b1;
          // Tie: alternate against the previous owner, or fixed M0 priority.
          grant_sel = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
        end else if (M0_Req) begin
          grant_en  = 1'b1;
          grant_sel = 1'b0;
        end else if (M1_Req) begin
          grant_en  = 1'b1;
          grant_sel = 1'b1;
        end
        if (grant_en) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ExtReady) begin
          capture_en = 1'b1;
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Wait out a level-style ExtReady so one response is never counted twice.
        if (!ExtReady) begin
          ready_set  = 1'b1;
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (!owner_req) begin
          ready_clr  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PixelClk2 or negedge RESETn) begin
    if (!RESETn) begin
      ExtAddr      <= '0;
      ExtDataWrite <= '0;
      ExtDataMask  <= '0;
      ExtOP        <= 1'b0;
      ExtReq       <= 1'b0;
      Grant        <= '0;
      last_grant   <= 1'b1;  // M0 wins the first tie
      wd_cnt       <= '0;
      Timeout      <= 1'b0;
      M0_Ready     <= 1'b0;
      M1_Ready     <= 1'b0;
      M0_DataRead  <= '0;
      M1_DataRead  <= '0;
    end else begin
      if (grant_en) begin
        // Command fields stay put after the transaction; only the next grant reloads them.
        ExtAddr      <= grant_sel ? M1_Addr      : M0_Addr;
        ExtDataWrite <= grant_sel ? M1_DataWrite : M0_DataWrite;
        ExtDataMask  <= grant_sel ? M1_DataMask  : M0_DataMask;
        ExtOP        <= grant_sel ? M1_OP        : M0_OP;
        ExtReq       <= 1'b1;
        Grant        <= grant_sel ? 2'b10 : 2'b01;
        last_grant   <= grant_sel;
        wd_cnt       <= '0;
      end

      if (capture_en) begin
        ExtReq <= 1'b0;
        if (Grant[1]) begin
          M1_DataRead <= ExtDataRead;
        end else begin
          M0_DataRead <= ExtDataRead;
        end
      end

      // Watchdog only flags a stuck controller; the transaction keeps waiting.
      if ((state == S_ISSUE) && !ExtReady) begin
        if (wd_cnt != 16'hFFFF) begin
          wd_cnt <= wd_cnt + 16'd1;
        end
        if (wd_cnt >= (TIMEOUT_W - 16'd1)) begin
          Timeout <= 1'b1;
        end
      end

      if (ready_set) begin
        if (Grant[1]) begin
          M1_Ready <= 1'b1;
        end else begin
          M0_Ready <= 1'b1;
        end
      end

      if (ready_clr) begin
        M0_Ready <= 1'b0;
        M1_Ready <= 1'b0;
        Grant    <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_sdram_ext_arbiter.sv
// Bench for sdram_ext_arbiter: instance 0 is round-robin, instance 1 fixed priority,
// both with a short watchdog. Table-driven cycle vectors plus handshake sequences.
module tb_sdram_ext_arbiter;

  localparam logic [23:0] A0 = 24'h001234;
  localparam logic [23:0] A1 = 24'hFFFFFF;

  logic clk;
  logic rst_n;

  // Command fields are constant per master for the whole run.
  logic [23:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic [1:0]  m0_mask, m1_mask;
  logic        m0_op, m1_op;

  logic [1:0]  m0_req, m1_req, ext_ready;
  logic [15:0] ext_rdata [2];

  logic        m0_rdy_o [2];
  logic        m1_rdy_o [2];
  logic        ext_req_o [2];
  logic        ext_op_o [2];
  logic        timeout_o [2];
  logic [1:0]  grant_o [2];
  logic [1:0]  ext_mask_o [2];
  logic [15:0] m0_rd_o [2];
  logic [15:0] m1_rd_o [2];
  logic [15:0] ext_wdata_o [2];
  logic [23:0] ext_addr_o [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sdram_ext_arbiter #(
      .ROUND_ROBIN((g == 0) ? 1 : 0),
      .TIMEOUT    (16)
    ) dut (
      .PixelClk2   (clk),
      .RESETn      (rst_n),
      .M0_Addr     (m0_addr),
      .M0_DataWrite(m0_wdata),
      .M0_DataMask (m0_mask),
      .M0_OP       (m0_op),
      .M0_Req      (m0_req[g]),
      .M0_Ready    (m0_rdy_o[g]),
      .M0_DataRead (m0_rd_o[g]),
      .M1_Addr     (m1_addr),
      .M1_DataWrite(m1_wdata),
      .M1_DataMask (m1_mask),
      .M1_OP       (m1_op),
      .M1_Req      (m1_req[g]),
      .M1_Ready    (m1_rdy_o[g]),
      .M1_DataRead (m1_rd_o[g]),
      .ExtAddr     (ext_addr_o[g]),
      .ExtDataWrite(ext_wdata_o[g]),
      .ExtDataMask (ext_mask_o[g]),
      .ExtOP       (ext_op_o[g]),
      .ExtReq      (ext_req_o[g]),
      .ExtReady    (ext_ready[g]),
      .ExtDataRead (ext_rdata[g]),
      .Grant       (grant_o[g]),
      .Timeout     (timeout_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_rise [2];
  bit have_rise [2];

  typedef struct {
    logic        r0, r1, er;
    logic [15:0] rd;
    logic [1:0]  g;
    logic        xr, y0, y1;
    logic [23:0] a;
    logic        op;
    logic [15:0] d0, d1;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic r0, logic r1, logic er, logic [15:0] rd, logic [1:0] g,
                              logic xr, logic y0, logic y1, logic [23:0] a, logic op,
                              logic [15:0] d0, logic [15:0] d1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.er = er; v.rd = rd; v.g = g; v.xr = xr; v.y0 = y0; v.y1 = y1;
    v.a = a; v.op = op; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_zero(input int d, input string pfx);
    chk({pfx, "_grant"},   grant_o[d], 0);
    chk({pfx, "_extreq"},  ext_req_o[d], 0);
    chk({pfx, "_extaddr"}, ext_addr_o[d], 0);
    chk({pfx, "_extwd"},   ext_wdata_o[d], 0);
    chk({pfx, "_extmask"}, ext_mask_o[d], 0);
    chk({pfx, "_extop"},   ext_op_o[d], 0);
    chk({pfx, "_m0rdy"},   m0_rdy_o[d], 0);
    chk({pfx, "_m1rdy"},   m1_rdy_o[d], 0);
    chk({pfx, "_m0rd"},    m0_rd_o[d], 0);
    chk({pfx, "_m1rd"},    m1_rd_o[d], 0);
    chk({pfx, "_timeout"}, timeout_o[d], 0);
  endtask

  // One full transaction with a pulse-style ExtReady; the owner then drops Req
  // for one cycle and, if asked, raises it again.
  task automatic serve(input int d, input logic [1:0] exp_g, input logic reassert);
    int n;
    logic own;
    logic [15:0] data;
    n = 0;
    while (ext_req_o[d] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk($sformatf("serve%0d_extreq", d), ext_req_o[d], 1);
    if (have_rise[d]) begin
      chk($sformatf("serve%0d_spacing_ge3(gap=%0d)", d, cyc - last_rise[d]),
          {31'b0, (cyc - last_rise[d]) >= 3}, 1);
    end
    last_rise[d] = cyc;
    have_rise[d] = 1'b1;
    chk($sformatf("serve%0d_grant", d), grant_o[d], exp_g);
    own  = exp_g[1];
    data = 16'h4000 + 16'(cyc);
    ext_rdata[d] = data;
    ext_ready[d] = 1'b1;
    step();
    ext_ready[d] = 1'b0;
    step();
    chk($sformatf("serve%0d_owner_rdy", d), own ? m1_rdy_o[d] : m0_rdy_o[d], 1);
    chk($sformatf("serve%0d_other_rdy", d), own ? m0_rdy_o[d] : m1_rdy_o[d], 0);
    chk($sformatf("serve%0d_rdata", d), own ? m1_rd_o[d] : m0_rd_o[d], data);
    if (own) m1_req[d] = 1'b0;
    else     m0_req[d] = 1'b0;
    step();
    chk($sformatf("serve%0d_idle_grant", d), grant_o[d], 0);
    if (reassert) begin
      if (own) m1_req[d] = 1'b1;
      else     m0_req[d] = 1'b1;
    end
  endtask

  initial begin
    m0_addr = A0;  m0_wdata = 16'h1111; m0_mask = 2'b00; m0_op = 1'b0;
    m1_addr = A1;  m1_wdata = 16'hA5A5; m1_mask = 2'b01; m1_op = 1'b1;
    m0_req = '0; m1_req = '0; ext_ready = '0;
    ext_rdata[0] = '0; ext_rdata[1] = '0;
    last_rise[0] = 0; last_rise[1] = 0;
    have_rise[0] = 1'b0; have_rise[1] = 1'b0;
    rst_n = 1'b0;

    // columns: M0_Req M1_Req ExtReady ExtDataRead | Grant ExtReq M0_Ready M1_Ready ExtAddr ExtOP M0_DataRead M1_DataRead
    // single M0 read, ExtReady pulse 5 cycles after ExtReq
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1,0,0,16'h0000, 2'b01,1,0,0, A0,0, 16'h0000,16'h0000));
    tbl.push_back(mk(1,0,1,16'hBEEF, 2'b01,0,0,0, A0,0, 16'hBEEF,16'h0000));
    tbl.push_back(mk(1,0,0,16'h0000, 2'b01,0,1,0, A0,0, 16'hBEEF,16'h0000));
    tbl.push_back(mk(1,0,0,16'h0000, 2'b01,0,1,0, A0,0, 16'hBEEF,16'h0000));
    tbl.push_back(mk(0,0,0,16'h0000, 2'b00,0,0,0, A0,0, 16'hBEEF,16'h0000));
    // M1 write; M0 must see no Ready
    tbl.push_back(mk(0,1,0,16'h0000, 2'b10,1,0,0, A1,1, 16'hBEEF,16'h0000));
    tbl.push_back(mk(0,1,1,16'h0F0F, 2'b10,0,0,0, A1,1, 16'hBEEF,16'h0F0F));
    tbl.push_back(mk(0,1,0,16'h0000, 2'b10,0,0,1, A1,1, 16'hBEEF,16'h0F0F));
    tbl.push_back(mk(0,0,0,16'h0000, 2'b00,0,0,0, A1,1, 16'hBEEF,16'h0F0F));
    // ExtReady in IDLE ignored
    tbl.push_back(mk(0,0,1,16'hDEAD, 2'b00,0,0,0, A1,1, 16'hBEEF,16'h0F0F));
    // level-style ExtReady held 4 cycles; only the ISSUE cycle captures data
    tbl.push_back(mk(1,0,0,16'h0000, 2'b01,1,0,0, A0,0, 16'hBEEF,16'h0F0F));
    tbl.push_back(mk(1,0,1,16'h1357, 2'b01,0,0,0, A0,0, 16'h1357,16'h0F0F));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,1,16'h9999, 2'b01,0,0,0, A0,0, 16'h1357,16'h0F0F));
    tbl.push_back(mk(1,0,0,16'h0000, 2'b01,0,1,0, A0,0, 16'h1357,16'h0F0F));
    // ExtReady in ACK ignored
    tbl.push_back(mk(1,0,1,16'h2468, 2'b01,0,1,0, A0,0, 16'h1357,16'h0F0F));
    tbl.push_back(mk(0,0,0,16'h0000, 2'b00,0,0,0, A0,0, 16'h1357,16'h0F0F));
    // M1 drops Req early (one-cycle Ready); M0 raises Req meanwhile and waits for IDLE
    tbl.push_back(mk(0,1,0,16'h0000, 2'b10,1,0,0, A1,1, 16'h1357,16'h0F0F));
    tbl.push_back(mk(1,0,0,16'h0000, 2'b10,1,0,0, A1,1, 16'h1357,16'h0F0F));
    tbl.push_back(mk(1,0,1,16'hABCD, 2'b10,0,0,0, A1,1, 16'h1357,16'hABCD));
    tbl.push_back(mk(1,0,0,16'h0000, 2'b10,0,0,1, A1,1, 16'h1357,16'hABCD));
    tbl.push_back(mk(1,0,0,16'h0000, 2'b00,0,0,0, A1,1, 16'h1357,16'hABCD));
    tbl.push_back(mk(1,0,0,16'h0000, 2'b01,1,0,0, A0,0, 16'h1357,16'hABCD));
    tbl.push_back(mk(1,0,1,16'h5555, 2'b01,0,0,0, A0,0, 16'h5555,16'hABCD));
    tbl.push_back(mk(1,0,0,16'h0000, 2'b01,0,1,0, A0,0, 16'h5555,16'hABCD));
    tbl.push_back(mk(0,0,0,16'h0000, 2'b00,0,0,0, A0,0, 16'h5555,16'hABCD));
    // short M1 transaction so M1 is the last owner before the tie test
    tbl.push_back(mk(0,1,0,16'h0000, 2'b10,1,0,0, A1,1, 16'h5555,16'hABCD));
    tbl.push_back(mk(0,1,1,16'h7777, 2'b10,0,0,0, A1,1, 16'h5555,16'h7777));
    tbl.push_back(mk(0,1,0,16'h0000, 2'b10,0,0,1, A1,1, 16'h5555,16'h7777));
    tbl.push_back(mk(0,0,0,16'h0000, 2'b00,0,0,0, A1,1, 16'h5555,16'h7777));

    // reset state
    step();
    step();
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      m0_req[0]    = tbl[i].r0;
      m1_req[0]    = tbl[i].r1;
      ext_ready[0] = tbl[i].er;
      ext_rdata[0] = tbl[i].rd;
      step();
      chk($sformatf("v%0d_grant", i),  grant_o[0],    tbl[i].g);
      chk($sformatf("v%0d_extreq", i), ext_req_o[0],  tbl[i].xr);
      chk($sformatf("v%0d_m0rdy", i),  m0_rdy_o[0],   tbl[i].y0);
      chk($sformatf("v%0d_m1rdy", i),  m1_rdy_o[0],   tbl[i].y1);
      chk($sformatf("v%0d_addr", i),   ext_addr_o[0], tbl[i].a);
      chk($sformatf("v%0d_op", i),     ext_op_o[0],   tbl[i].op);
      chk($sformatf("v%0d_m0rd", i),   m0_rd_o[0],    tbl[i].d0);
      chk($sformatf("v%0d_m1rd", i),   m1_rd_o[0],    tbl[i].d1);
    end
    // last grant was the M1 write: its fields must still be on Ext in IDLE
    chk("write_wdata", ext_wdata_o[0], 16'hA5A5);
    chk("write_mask",  ext_mask_o[0],  2'b01);
    chk("tbl_timeout", timeout_o[0],   0);

    // round-robin contention: strict alternation starting with M0
    m0_req[0] = 1'b1;
    m1_req[0] = 1'b1;
    for (int t = 0; t < 6; t++) begin
      serve(0, (t % 2 == 1) ? 2'b10 : 2'b01, t < 5);
    end
    m0_req[0] = 1'b0;
    step();

    // fixed priority: M1 starves until M0 stops requesting
    m0_req[1] = 1'b1;
    m1_req[1] = 1'b1;
    for (int t = 0; t < 3; t++) serve(1, 2'b01, 1'b1);
    serve(1, 2'b01, 1'b0);
    serve(1, 2'b10, 1'b0);
    step();
    chk("fp_end_grant", grant_o[1], 0);

    // watchdog: no ExtReady at all
    m0_req[0] = 1'b1;
    step();
    chk("to_grant", grant_o[0], 2'b01);
    for (int i = 0; i < 15; i++) step();
    chk("to_after15", timeout_o[0], 0);
    step();
    chk("to_after16", timeout_o[0], 1);
    for (int i = 0; i < 3; i++) step();
    chk("to_sticky", timeout_o[0], 1);
    chk("to_not_aborted", ext_req_o[0], 1);

    // asynchronous reset mid-ISSUE, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(0, "arst");
    m0_req[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m1_req[0] = 1'b1;
    step();
    chk("post_rst_grant",   grant_o[0],    2'b10);
    chk("post_rst_extreq",  ext_req_o[0],  1);
    chk("post_rst_addr",    ext_addr_o[0], A1);
    chk("post_rst_timeout", timeout_o[0],  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
